if_prefetch_queue: RTL
======================

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-002 SHALL have parameter RESET_PC, default 32'hBFC0_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush  input  1  redirect from branch/jump/jr resolution.
REQ-006 SHALL have port flush_addr  input  32  redirect target address.
REQ-007 SHALL have port isram_req  output  1  instruction SRAM request.
REQ-008 SHALL have port isram_addr  output  32  request word address.
REQ-009 SHALL have port isram_gnt  input  1  request accepted this cycle.
REQ-010 SHALL have port isram_rvalid  input  1  read data valid, one response per grant, in order.
REQ-011 SHALL have port isram_rdata  input  32  instruction word.
REQ-012 SHALL have port if_valid  output  1  head entry valid toward if_id.
REQ-013 SHALL have port if_inst / if_cur_instaddress / if_next_instaddress  output  32 each  head word, its address, address+4.
REQ-014 SHALL have port if_ready  input  1  consumer accepts head (low = stall_if_id).

Function
REQ-015 SHALL track fetch_pc; increments by 4 on each grant; loaded with flush_addr on flush.
REQ-016 SHALL run FSM S_IDLE, S_REQ, S_WAIT, S_KILL.
REQ-017 S_IDLE->S_REQ when free slots (DEPTH minus occupancy minus outstanding) > 0.
REQ-018 S_REQ: isram_req=1, isram_addr=fetch_pc held stable until isram_gnt; gnt->S_WAIT.
REQ-019 S_WAIT: on isram_rvalid, write {rdata, addr} at tail; ->S_REQ if slot free, else S_IDLE.
REQ-020 At most one outstanding request; isram_req SHALL be low in S_WAIT and S_KILL.
REQ-021 Dequeue when if_valid && if_ready; head pointer advances, wraps modulo DEPTH.
REQ-022 Enqueue and dequeue in same cycle SHALL leave occupancy unchanged, including when full.
REQ-023 Full: no request issued; empty: if_valid=0, outputs hold last value.
REQ-024 flush SHALL empty queue next cycle, set fetch_pc=flush_addr; if_valid=0 the cycle after flush.
REQ-025 flush in S_WAIT (or in S_REQ same cycle as gnt) ->S_KILL; next rvalid discarded, then ->S_REQ.
REQ-026 flush in S_REQ without gnt SHALL abandon request; next request uses flush_addr.
REQ-027 flush has priority over simultaneous enqueue and dequeue.
REQ-028 Minimum latency: gnt at cycle N, rvalid at N+1, if_valid at N+2 (bypass off).

Reset
REQ-029 On rst=0 at clock edge: queue empty, pointers 0, FSM S_IDLE, fetch_pc=RESET_PC, kill flag clear.
REQ-030 During reset: isram_req=0, if_valid=0, if_inst=0, if_cur_instaddress=0, if_next_instaddress=0.
REQ-031 Reset mid-transaction SHALL drop in-flight response; first post-reset request address RESET_PC.

Configuration
REQ-032 Macro PREFETCH_BYPASS_EN: defined -> when queue empty and rvalid (not killed), rdata drives if_* same cycle with if_valid=1; entry written only if if_ready=0.
REQ-033 Macro undefined -> all data passes through queue storage; latency per REQ-028.

Structure
REQ-034 Shared package SHALL hold FSM state encoding, RESET_PC default, word size constant 4.
REQ-035 Sub-module prefetch_fifo (storage, pointers, count, full/empty) SHALL be separate; FSM and fetch_pc stay in top module.

Verification
REQ-036 Reset then gnt and rvalid always 1, if_ready=1 -> if_cur_instaddress BFC00000, BFC00004, BFC00008 on consecutive valid cycles.
REQ-037 if_ready=0 for 10 cycles -> exactly 4 entries, isram_req=0 while full; release -> 4 words in order, no loss.
REQ-038 flush with flush_addr=0x80001000 in S_WAIT -> in-flight rvalid discarded; next if_valid shows 0x80001000.
REQ-039 flush and isram_gnt same cycle -> that response dropped; next isram_addr=flush_addr.
REQ-040 rst=0 asserted in S_WAIT with queue holding 2 entries -> next cycle if_valid=0, isram_req=0; fetch resumes at BFC00000.
REQ-041 PREFETCH_BYPASS_EN defined, empty queue, rvalid with rdata=0x24020001, if_ready=1 -> if_valid=1, if_inst=0x24020001 same cycle; count stays 0.

Source files
------------

// File: rtl/if_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: FSM encoding, reset PC, word size.
`default_nettype none

package if_prefetch_queue_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_KILL = 2'd3
   } state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
   localparam logic [31:0] WORD_BYTES       = 32'd4;

endpackage

`default_nettype wire

// File: rtl/prefetch_fifo.sv
// Circular storage for fetched {instruction, address} pairs with occupancy tracking.
`default_nettype none

module prefetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    head;
   logic [AW-1:0]    tail;
   logic             do_wr;
   logic             do_rd;

   // A write into a full queue is legal only when the head leaves in the same cycle.
   assign do_wr   = wr_en && (!full || rd_en);
   assign do_rd   = rd_en && !empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[head];

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_wr) tail <= tail + 1'b1;
         if (do_rd) head <= head + 1'b1;
         if (do_wr && !do_rd)
            count <= count + 1'b1;
         else if (!do_wr && do_rd)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr && rst && !clear) mem[tail] <= wr_data;
   end

endmodule

`default_nettype wire

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: fetch FSM and PC in front of prefetch_fifo.
// Optional same-cycle bypass of an empty queue when PREFETCH_BYPASS_EN is defined.
`default_nettype none

module if_prefetch_queue
   import if_prefetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] flush_addr,
   output logic        isram_req,
   output logic [31:0] isram_addr,
   input  logic        isram_gnt,
   input  logic        isram_rvalid,
   input  logic [31:0] isram_rdata,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_cur_instaddress,
   output logic [31:0] if_next_instaddress,
   input  logic        if_ready
);

   localparam int            CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   state_t        state;
   state_t        state_nx;
   logic [31:0]   fetch_pc;
   logic [31:0]   req_addr;
   logic [CW-1:0] count;
   logic [CW-1:0] used;
   logic [CW-1:0] used_after;
   logic          full;
   logic          empty;
   logic [63:0]   head_data;
   logic          wr_en;
   logic          rd_en;
   logic          resp;
   logic          bypass_hit;
   logic [31:0]   hold_inst;
   logic [31:0]   hold_addr;
   logic [31:0]   hold_next;

   assign isram_req  = (state == S_REQ);
   assign isram_addr = fetch_pc;
   assign resp       = (state == S_WAIT) && isram_rvalid && !flush;
   // An outstanding request has already claimed a slot.
   assign used       = count + ((state == S_WAIT) ? CW'(1) : CW'(0));

`ifdef PREFETCH_BYPASS_EN
   assign bypass_hit = empty && resp;
   assign wr_en      = resp && !(bypass_hit && if_ready);
`else
   assign bypass_hit = 1'b0;
   assign wr_en      = resp;
`endif

   assign rd_en      = !empty && if_ready && !flush;
   assign used_after = count + CW'(wr_en) - CW'(rd_en);

   prefetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear   (flush),
      .wr_en   (wr_en),
      .wr_data ({isram_rdata, req_addr}),
      .rd_en   (rd_en),
      .rd_data (head_data),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         req_addr <= '0;
      end else begin
         state <= state_nx;
         if (flush)
            fetch_pc <= flush_addr;
         else if (isram_req && isram_gnt)
            fetch_pc <= fetch_pc + WORD_BYTES;
         if (isram_req && isram_gnt)
            req_addr <= fetch_pc;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (flush || (!full && used < DEPTH_C)) state_nx = S_REQ;
         S_REQ:  if (isram_gnt) state_nx = flush ? S_KILL : S_WAIT;
         // A response landing with the flush is already discarded; nothing is left to kill.
         S_WAIT: begin
            if (flush)
               state_nx = isram_rvalid ? S_REQ : S_KILL;
            else if (isram_rvalid)
               state_nx = (used_after < DEPTH_C) ? S_REQ : S_IDLE;
         end
         S_KILL: if (isram_rvalid) state_nx = S_REQ;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      if_valid            = !empty;
      if_inst             = head_data[63:32];
      if_cur_instaddress  = head_data[31:0];
      if_next_instaddress = head_data[31:0] + WORD_BYTES;
      if (bypass_hit) begin
         if_valid            = 1'b1;
         if_inst             = isram_rdata;
         if_cur_instaddress  = req_addr;
         if_next_instaddress = req_addr + WORD_BYTES;
      end else if (empty) begin
         if_inst             = hold_inst;
         if_cur_instaddress  = hold_addr;
         if_next_instaddress = hold_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hold_inst <= '0;
         hold_addr <= '0;
         hold_next <= '0;
      end else if (if_valid && if_ready) begin
         hold_inst <= if_inst;
         hold_addr <= if_cur_instaddress;
         hold_next <= if_next_instaddress;
      end
   end

endmodule

`default_nettype wire
